// File: rtl/circular_pointer_fifo_np2.sv
// -----------------------------------------------------------------------------
// circular_pointer_fifo_np2
//
// Single-clock FIFO built on a register array with circular read/write
// pointers. DEPTH may be any integer >= 2, so each pointer wraps explicitly
// at DEPTH-1 instead of relying on natural binary rollover. Occupancy is
// tracked in a dedicated counter, and every status flag is decoded from
// that counter.
//
// Parameters:
//   WIDTH     data word width in bits (>= 1)
//   DEPTH     number of storage entries (>= 2, power of two not required)
//   AF_LEVEL  almost_full asserts when count >= AF_LEVEL
//   AE_LEVEL  almost_empty asserts when count <= AE_LEVEL
//
// Ports:
//   clk           rising-edge clock
//   rst           asynchronous, active-high reset
//   push          write request; data_in is stored when the push is accepted
//   data_in       write data
//   pop           read request
//   clr_err       synchronous clear of overflow/underflow (set wins)
//   data_out      registered read data; holds its value between reads
//   data_out_vld  one-cycle strobe following every accepted pop
//   empty         count == 0
//   full          count == DEPTH
//   almost_full   count >= AF_LEVEL
//   almost_empty  count <= AE_LEVEL
//   count         current occupancy, 0..DEPTH
//   overflow      sticky: a push was rejected
//   underflow     sticky: a pop was rejected
// -----------------------------------------------------------------------------
module circular_pointer_fifo_np2 #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 5,
  parameter int AF_LEVEL = DEPTH - 1,
  parameter int AE_LEVEL = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           data_in,
  input  logic                       pop,
  input  logic                       clr_err,
  output logic [WIDTH-1:0]           data_out,
  output logic                       data_out_vld,
  output logic                       empty,
  output logic                       full,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int PTR_W = ($clog2(DEPTH) > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_next;
  logic             pop_ok;
  logic             push_ok;

  // Explicit wrap keeps the pointer inside 0..DEPTH-1 even when DEPTH is
  // not a power of two, so values >= DEPTH can never be produced.
  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  // ---------------------------------------------------------------------------
  // Acceptance and next-count decode
  // ---------------------------------------------------------------------------
  // NOTE: every signal is given a default at the top of the always_comb so no
  // path leaves it unassigned; that is what keeps a latch from being inferred.
  always_comb begin
    pop_ok     = 1'b0;
    push_ok    = 1'b0;
    count_next = count;

    pop_ok  = pop && (count != '0);
    // A push while full is legal only when the same-cycle pop frees a slot.
    push_ok = push && ((count != CNT_FULL) || pop_ok);

    unique case ({push_ok, pop_ok})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  // NOTE: the array carries no reset. Validity is tracked by count and the
  // pointers, so the contents left over after reset are never observable, and
  // leaving the memory out of the reset lets it map onto plain registers/RAM.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= data_in;
    end
  end

  // ---------------------------------------------------------------------------
  // Pointers, occupancy, read port
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every register samples the pre-edge value of every other register and the
  // result does not depend on process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      data_out     <= '0;
      data_out_vld <= 1'b0;
    end else begin
      count        <= count_next;
      data_out_vld <= pop_ok;
      if (push_ok) begin
        wr_ptr <= ptr_next(wr_ptr);
      end
      if (pop_ok) begin
        // When full with push and pop together, rd_ptr == wr_ptr: the read
        // sees the old word because the memory write lands at the same edge.
        data_out <= mem[rd_ptr];
        rd_ptr   <= ptr_next(rd_ptr);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Sticky error flags: a new rejection outranks a same-cycle clear
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= (push && !push_ok) || (overflow  && !clr_err);
      underflow <= (pop  && !pop_ok)  || (underflow && !clr_err);
    end
  end

  // ---------------------------------------------------------------------------
  // Status flags, decoded from the count register only (no path from push/pop)
  // ---------------------------------------------------------------------------
  assign empty        = (count == '0);
  assign full         = (count == CNT_FULL);
  assign almost_full  = (int'(count) >= AF_LEVEL);
  assign almost_empty = (int'(count) <= AE_LEVEL);

endmodule

// File: tb/tb_circular_pointer_fifo_np2.sv
// -----------------------------------------------------------------------------
// Scoreboard bench for circular_pointer_fifo_np2.
// The reference model is a plain queue of words plus a few flag bits. When the
// stimulus side issues a pop the model accepts, the expected word is queued;
// a separate monitor pops and compares whenever data_out_vld is high.
// A second instance (DEPTH=7, AF_LEVEL=6, AE_LEVEL=2) covers the thresholds.
// -----------------------------------------------------------------------------
module tb_circular_pointer_fifo_np2;

  localparam int W  = 8;
  localparam int D  = 5;
  localparam int D7 = 7;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // DEPTH=5 instance
  logic         push, pop, clr_err;
  logic [W-1:0] data_in, data_out;
  logic         data_out_vld, empty, full, almost_full, almost_empty;
  logic [2:0]   count;
  logic         overflow, underflow;

  // DEPTH=7 instance
  logic         push_7, pop_7, clr_err_7;
  logic [W-1:0] data_in_7, data_out_7;
  logic         data_out_vld_7, empty_7, full_7, almost_full_7, almost_empty_7;
  logic [2:0]   count_7;
  logic         overflow_7, underflow_7;

  circular_pointer_fifo_np2 #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .push(push), .data_in(data_in), .pop(pop),
    .clr_err(clr_err), .data_out(data_out), .data_out_vld(data_out_vld),
    .empty(empty), .full(full), .almost_full(almost_full),
    .almost_empty(almost_empty), .count(count), .overflow(overflow),
    .underflow(underflow)
  );

  circular_pointer_fifo_np2 #(.WIDTH(W), .DEPTH(D7), .AF_LEVEL(6), .AE_LEVEL(2)) dut7 (
    .clk(clk), .rst(rst), .push(push_7), .data_in(data_in_7), .pop(pop_7),
    .clr_err(clr_err_7), .data_out(data_out_7), .data_out_vld(data_out_vld_7),
    .empty(empty_7), .full(full_7), .almost_full(almost_full_7),
    .almost_empty(almost_empty_7), .count(count_7), .overflow(overflow_7),
    .underflow(underflow_7)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  logic [W-1:0] mq[$];      // words currently held
  logic [W-1:0] exp_q[$];   // words the DUT owes on data_out
  bit           m_ov, m_un, m_vld;
  logic [W-1:0] m_dout;
  int           c7;

  task automatic model_reset();
    mq.delete();
    m_ov = 0; m_un = 0; m_vld = 0; m_dout = '0;
    c7 = 0;
  endtask

  task automatic check_flags();
    int n = mq.size();
    check("count",        count,        n);
    check("empty",        empty,        n == 0);
    check("full",         full,         n == D);
    check("almost_full",  almost_full,  n >= D - 1);
    check("almost_empty", almost_empty, n <= 1);
    check("overflow",     overflow,     m_ov);
    check("underflow",    underflow,    m_un);
    check("data_out_vld", data_out_vld, m_vld);
    check("data_out",     data_out,     m_dout);
  endtask

  // One clock of stimulus on the DEPTH=5 instance, with model update.
  task automatic step(input bit p, input bit q, input logic [W-1:0] d, input bit clr);
    bit pop_ok, push_ok;
    push = p; pop = q; data_in = d; clr_err = clr;
    pop_ok  = q && (mq.size() != 0);
    push_ok = p && ((mq.size() != D) || pop_ok);
    if (pop_ok) begin
      m_dout = mq.pop_front();
      exp_q.push_back(m_dout);
    end
    if (push_ok) mq.push_back(d);
    m_ov  = (p && !push_ok) || (m_ov && !clr);
    m_un  = (q && !pop_ok)  || (m_un && !clr);
    m_vld = pop_ok;
    @(posedge clk); #1;
    check_flags();
    push = 0; pop = 0; clr_err = 0;
  endtask

  task automatic drain();
    while (mq.size() != 0) step(0, 1, '0, 0);
    step(0, 0, '0, 0);
  endtask

  // One clock on the DEPTH=7 instance; only occupancy-driven flags modelled.
  task automatic step7(input bit p, input bit q);
    push_7 = p; pop_7 = q; data_in_7 = 8'(c7);
    if (p && !q && c7 < D7) c7++;
    else if (q && !p && c7 > 0) c7--;
    @(posedge clk); #1;
    check("count_7",        count_7,        c7);
    check("empty_7",        empty_7,        c7 == 0);
    check("full_7",         full_7,         c7 == D7);
    check("almost_full_7",  almost_full_7,  c7 >= 6);
    check("almost_empty_7", almost_empty_7, c7 <= 2);
    push_7 = 0; pop_7 = 0;
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: compare every strobed output against the scoreboard
  // ---------------------------------------------------------------------------
  always @(posedge clk) begin
    #1;
    if (data_out_vld === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_vld: got data %0h with no word expected at %0t", data_out, $time);
      end else begin
        check("scoreboard_data", data_out, exp_q.pop_front());
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [W-1:0] v;
    rst = 1'b1;
    push = 0; pop = 0; clr_err = 0; data_in = '0;
    push_7 = 0; pop_7 = 0; clr_err_7 = 0; data_in_7 = '0;
    model_reset();
    #12;
    check_flags();
    check("count_7_rst", count_7, 0);
    check("ae_7_rst",    almost_empty_7, 1);
    rst = 1'b0;

    // Fill and drain
    for (int i = 1; i <= 5; i++) step(1, 0, 8'(i * 8'h11), 0);
    drain();

    // Wrap-around: hold occupancy at 2..3 while both pointers lap twice
    step(1, 0, 8'hA0, 0);
    step(1, 0, 8'hA1, 0);
    for (int i = 0; i < 12; i++) begin
      if (i % 3 == 0) step(1, 0, 8'(8'hB0 + i), 0);
      else if (i % 3 == 1) step(0, 1, '0, 0);
      else step(1, 1, 8'(8'hB0 + i), 0);
    end
    drain();

    // Overflow
    for (int i = 0; i < 5; i++) step(1, 0, 8'(8'h21 + i), 0);
    step(1, 0, 8'hAA, 0);
    step(1, 1, 8'hCC, 0);
    step(0, 0, '0, 1);
    drain();

    // Underflow, then push+pop while empty
    step(0, 1, '0, 0);
    step(1, 1, 8'h77, 0);
    step(0, 0, '0, 1);
    drain();

    // Thresholds on the DEPTH=7 instance
    for (int i = 0; i < D7; i++) step7(1, 0);
    step7(0, 0);
    for (int i = 0; i < D7; i++) step7(0, 1);

    // Async reset mid-operation with count=3 and error flag set
    step(0, 1, '0, 0);
    for (int i = 0; i < 4; i++) step(1, 0, 8'(8'h31 + i), 0);
    step(0, 1, '0, 0);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_flags();
    #2 rst = 1'b0;
    step(1, 0, 8'h5A, 0);
    step(0, 1, '0, 0);
    step(0, 0, '0, 0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      v = 8'($urandom);
      step($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 5, v,
           $urandom_range(0, 19) == 0);
    end
    drain();

    check("scoreboard_leftover", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
